tilelink_ul_master_mo: RTL and testbench

//  TL-UL master with multiple outstanding requests for the low-speed peripheral domain (GPIO, flash).

---
 rtl/tl_ul_pkg.sv | 33 +++
 rtl/tl_ul_sync_fifo.sv | 56 +++++
 rtl/tilelink_ul_master_mo.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_tilelink_ul_master_mo.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_ul_pkg.sv
// Shared TL-UL definitions for the low-speed peripheral master.
//   - A/D channel opcode encodings
//   - issue FSM state type
//   - is_legal_ul_opcode: true for PutFullData, PutPartialData and Get
//   - expected_d_opcode: D opcode a well-behaved slave returns for a request
// Optional feature macro used by the master: TL_UL_MASTER_TIMEOUT_EN.
package tl_ul_pkg;

  localparam logic [2:0] TL_A_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_A_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_A_GET             = 3'd4;
  localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } issue_state_e;

  function automatic logic is_legal_ul_opcode(input logic [2:0] opcode);
    logic legal;
    case (opcode)
      TL_A_PUT_FULL, TL_A_PUT_PARTIAL, TL_A_GET: legal = 1'b1;
      default:                                   legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic [2:0] expected_d_opcode(input logic is_get);
    return is_get ? TL_D_ACCESS_ACK_DATA : TL_D_ACCESS_ACK;
  endfunction

endpackage

// File: rtl/tl_ul_sync_fifo.sv
// Synchronous FIFO used as the master's command queue.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties the queue)
//   push, push_data write side; a push while full is taken only alongside a pop
//   pop, pop_data   read side; pop_data shows the head entry (valid when !empty)
//   full, empty     occupancy flags
// DEPTH must be a power of two, >= 2.
module tl_ul_sync_fifo
  import tl_ul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit so full and empty can be told apart.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Read/write pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {(AW+1){1'b0}};
      rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tilelink_ul_master_mo.sv
// TL-UL master with multiple outstanding requests (GPIO / flash domain).
// User commands are queued, each is given the lowest free source ID, issued on
// channel A (held stable until accepted) and D responses are handed back to the
// user in arrival order through a one-entry response register.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   cmd_*                      user command (valid/ready, opcode, address, size, mask, data)
//   a_*                        TL-UL channel A master outputs, a_ready input
//   d_*                        TL-UL channel D slave inputs, d_ready output
//   rsp_*                      user response (valid/ready, opcode, source, data, error)
//   outstanding                number of allocated source IDs
//   protocol_err               sticky: illegal command, unknown D source or wrong D opcode
//   timeout                    sticky watchdog flag, present only with TL_UL_MASTER_TIMEOUT_EN
// Macro TL_UL_MASTER_TIMEOUT_EN enables the in-flight watchdog (TIMEOUT_CYCLES).
module tilelink_ul_master_mo
  import tl_ul_pkg::*;
#(
  parameter int TL_ADDR_WIDTH   = 64,
  parameter int TL_DATA_WIDTH   = 64,
  parameter int TL_SOURCE_WIDTH = 3,
  parameter int TL_SINK_WIDTH   = 3,
  parameter int TL_SIZE_WIDTH   = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CMD_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd_opcode,
  input  logic [TL_ADDR_WIDTH-1:0]     cmd_address,
  input  logic [TL_SIZE_WIDTH-1:0]     cmd_size,
  input  logic [TL_DATA_WIDTH/8-1:0]   cmd_mask,
  input  logic [TL_DATA_WIDTH-1:0]     cmd_data,
  output logic                         a_valid,
  input  logic                         a_ready,
  output logic [2:0]                   a_opcode,
  output logic [2:0]                   a_param,
  output logic [TL_ADDR_WIDTH-1:0]     a_address,
  output logic [TL_SIZE_WIDTH-1:0]     a_size,
  output logic [TL_DATA_WIDTH/8-1:0]   a_mask,
  output logic [TL_DATA_WIDTH-1:0]     a_data,
  output logic [TL_SOURCE_WIDTH-1:0]   a_source,
  input  logic                         d_valid,
  output logic                         d_ready,
  input  logic [2:0]                   d_opcode,
  input  logic [1:0]                   d_param,
  input  logic [TL_SIZE_WIDTH-1:0]     d_size,
  input  logic [TL_SINK_WIDTH-1:0]     d_sink,
  input  logic [TL_SOURCE_WIDTH-1:0]   d_source,
  input  logic [TL_DATA_WIDTH-1:0]     d_data,
  input  logic                         d_error,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [2:0]                   rsp_opcode,
  output logic [TL_SOURCE_WIDTH-1:0]   rsp_source,
  output logic [TL_DATA_WIDTH-1:0]     rsp_data,
  output logic                         rsp_error,
  output logic [TL_SOURCE_WIDTH:0]     outstanding,
  output logic                         protocol_err
`ifdef TL_UL_MASTER_TIMEOUT_EN
  ,
  output logic                         timeout
`endif
);

  localparam int STRB_W  = TL_DATA_WIDTH / 8;
  localparam int NUM_IDS = 2 ** TL_SOURCE_WIDTH;
  localparam int CMD_W   = 3 + TL_ADDR_WIDTH + TL_SIZE_WIDTH + STRB_W + TL_DATA_WIDTH;
  localparam logic [TL_SOURCE_WIDTH:0] OUT_ONE = {{TL_SOURCE_WIDTH{1'b0}}, 1'b1};

  // Command queue
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] fifo_wdata;
  logic [CMD_W-1:0] fifo_rdata;
  logic             cmd_hs;
  logic             cmd_legal;

  logic [2:0]                 q_opcode;
  logic [TL_ADDR_WIDTH-1:0]   q_address;
  logic [TL_SIZE_WIDTH-1:0]   q_size;
  logic [STRB_W-1:0]          q_mask;
  logic [TL_DATA_WIDTH-1:0]   q_data;

  // Issue FSM and ID tracking
  issue_state_e               state;
  issue_state_e               next_state;
  logic                       load;
  logic [NUM_IDS-1:0]         in_flight;
  logic [NUM_IDS-1:0]         is_get;
  logic                       free_avail;
  logic [TL_SOURCE_WIDTH-1:0] free_id;

  // D path
  logic d_hs;
  logic d_known;
  logic d_accept;
  logic d_opcode_bad;

  // Fields carried only for protocol completeness.
  logic unused_inputs;
  assign unused_inputs = ^{d_param, d_size, d_sink, (TIMEOUT_CYCLES > 0)};

  assign cmd_ready  = !fifo_full;
  assign cmd_hs     = cmd_valid && !fifo_full;
  assign cmd_legal  = is_legal_ul_opcode(cmd_opcode);
  // Illegal commands are acknowledged but never reach the queue.
  assign fifo_push  = cmd_hs && cmd_legal;
  assign fifo_wdata = {cmd_opcode, cmd_address, cmd_size, cmd_mask, cmd_data};
  assign {q_opcode, q_address, q_size, q_mask, q_data} = fifo_rdata;
  assign fifo_pop   = load;

  tl_ul_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Lowest free ID among the first MAX_OUTSTANDING; uses the registered bitmap
  // so an ID freed this cycle is only reusable from the next cycle.
  always_comb begin
    free_avail = 1'b0;
    free_id    = {TL_SOURCE_WIDTH{1'b0}};
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!in_flight[i]) begin
        free_avail = 1'b1;
        free_id    = TL_SOURCE_WIDTH'(i);
      end else begin
        free_avail = free_avail;
      end
    end
  end

  // Issue FSM next-state and queue-pop decision.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && free_avail) begin
          next_state = ST_ISSUE;
          load       = 1'b1;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (a_ready) begin
          if (!fifo_empty && free_avail) begin
            next_state = ST_ISSUE;
            load       = 1'b1;
          end else begin
            next_state = ST_IDLE;
          end
        end else begin
          next_state = ST_ISSUE;
        end
      end
      default: begin
        next_state = ST_IDLE;
        load       = 1'b0;
      end
    endcase
  end

  // Issue FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Channel A payload; only rewritten when a new command is loaded, so it stays
  // frozen while a_valid waits for a_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid   <= 1'b0;
      a_opcode  <= 3'd0;
      a_address <= {TL_ADDR_WIDTH{1'b0}};
      a_size    <= {TL_SIZE_WIDTH{1'b0}};
      a_mask    <= {STRB_W{1'b0}};
      a_data    <= {TL_DATA_WIDTH{1'b0}};
      a_source  <= {TL_SOURCE_WIDTH{1'b0}};
    end else begin
      a_valid <= (next_state == ST_ISSUE);
      if (load) begin
        a_opcode  <= q_opcode;
        a_address <= q_address;
        a_size    <= q_size;
        a_mask    <= q_mask;
        a_data    <= q_data;
        a_source  <= free_id;
      end
    end
  end

  assign a_param = 3'd0;

  assign d_ready      = !rsp_valid || rsp_ready;
  assign d_hs         = d_valid && d_ready;
  assign d_known      = in_flight[d_source];
  assign d_accept     = d_hs && d_known;
  assign d_opcode_bad = (d_opcode != expected_d_opcode(is_get[d_source]));

  // In-flight bitmap and per-ID request kind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight <= {NUM_IDS{1'b0}};
      is_get    <= {NUM_IDS{1'b0}};
    end else begin
      if (load) begin
        in_flight[free_id] <= 1'b1;
        is_get[free_id]    <= (q_opcode == TL_A_GET);
      end
      if (d_accept) in_flight[d_source] <= 1'b0;
    end
  end

  // In-flight counter; an allocate and a free in one cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= {(TL_SOURCE_WIDTH+1){1'b0}};
    end else begin
      case ({load, d_accept})
        2'b10:   outstanding <= outstanding + OUT_ONE;
        2'b01:   outstanding <= outstanding - OUT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // One-entry response register; beats for unknown sources are swallowed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_opcode <= 3'd0;
      rsp_source <= {TL_SOURCE_WIDTH{1'b0}};
      rsp_data   <= {TL_DATA_WIDTH{1'b0}};
      rsp_error  <= 1'b0;
    end else if (d_accept) begin
      rsp_valid  <= 1'b1;
      rsp_opcode <= d_opcode;
      rsp_source <= d_source;
      rsp_data   <= d_data;
      rsp_error  <= d_error;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  // Sticky protocol-violation flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      protocol_err <= 1'b0;
    end else if ((cmd_hs && !cmd_legal) || (d_hs && !d_known) || (d_accept && d_opcode_bad)) begin
      protocol_err <= 1'b1;
    end
  end

`ifdef TL_UL_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TW_ONE = TW'(1);

  logic [TW-1:0] wd_cnt;
  logic [TW-1:0] wd_cnt_next;

  // Watchdog next count: restart on any D handshake, saturate at the limit.
  always_comb begin
    wd_cnt_next = wd_cnt;
    if (d_hs) begin
      wd_cnt_next = {TW{1'b0}};
    end else if ((outstanding != {(TL_SOURCE_WIDTH+1){1'b0}}) && (wd_cnt != TMAX)) begin
      wd_cnt_next = wd_cnt + TW_ONE;
    end else begin
      wd_cnt_next = wd_cnt;
    end
  end

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt  <= {TW{1'b0}};
      timeout <= 1'b0;
    end else begin
      wd_cnt <= wd_cnt_next;
      if (wd_cnt_next == TMAX) timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tilelink_ul_master_mo.sv
// Directed self-checking bench for tilelink_ul_master_mo (default parameters).
module tb_tilelink_ul_master_mo;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_opcode;
  logic [63:0] cmd_address;
  logic [7:0]  cmd_size;
  logic [7:0]  cmd_mask;
  logic [63:0] cmd_data;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [63:0] a_address;
  logic [7:0]  a_size;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic [2:0]  a_source;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [7:0]  d_size;
  logic [2:0]  d_sink;
  logic [2:0]  d_source;
  logic [63:0] d_data;
  logic        d_error;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_opcode;
  logic [2:0]  rsp_source;
  logic [63:0] rsp_data;
  logic        rsp_error;
  logic [3:0]  outstanding;
  logic        protocol_err;
`ifdef TL_UL_MASTER_TIMEOUT_EN
  logic        timeout;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int a_hs_cnt = 0;
  int rsp_cnt  = 0;
  logic [2:0] rsp_log [64];

  tilelink_ul_master_mo dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_address(cmd_address), .cmd_size(cmd_size), .cmd_mask(cmd_mask), .cmd_data(cmd_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_address(a_address), .a_size(a_size), .a_mask(a_mask), .a_data(a_data), .a_source(a_source),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
    .d_sink(d_sink), .d_source(d_source), .d_data(d_data), .d_error(d_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_opcode(rsp_opcode),
    .rsp_source(rsp_source), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .outstanding(outstanding), .protocol_err(protocol_err)
`ifdef TL_UL_MASTER_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel A handshake counter and user-response order log.
  always @(posedge clk) begin
    if (a_valid && a_ready) a_hs_cnt++;
    if (rsp_valid && rsp_ready) begin
      rsp_log[rsp_cnt % 64] = rsp_source;
      rsp_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] data);
    cmd_valid   = 1'b1;
    cmd_opcode  = op;
    cmd_address = addr;
    cmd_size    = 8'd3;
    cmd_mask    = 8'hFF;
    cmd_data    = data;
    cyc();
    cmd_valid   = 1'b0;
  endtask

  task automatic send_d(input logic [2:0] src, input logic [2:0] op, input logic [63:0] data, input logic err);
    d_valid  = 1'b1;
    d_source = src;
    d_opcode = op;
    d_data   = data;
    d_error  = err;
    #1;
    for (int i = 0; i < 20 && !d_ready; i++) cyc();
    check_eq("d_ready_wait", {63'd0, d_ready}, 64'd1);
    cyc();
    d_valid = 1'b0;
  endtask

  initial begin
    int base;
    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = 3'd0; cmd_address = 64'd0; cmd_size = 8'd0;
    cmd_mask = 8'd0; cmd_data = 64'd0; a_ready = 1'b0; d_valid = 1'b0; d_opcode = 3'd0;
    d_param = 2'd0; d_size = 8'd0; d_sink = 3'd0; d_source = 3'd0; d_data = 64'd0;
    d_error = 1'b0; rsp_ready = 1'b1;
    repeat (3) cyc();
    check_eq("rst_a_valid", {63'd0, a_valid}, 64'd0);
    check_eq("rst_a_address", a_address, 64'd0);
    check_eq("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check_eq("rst_outstanding", {60'd0, outstanding}, 64'd0);
    check_eq("rst_protocol_err", {63'd0, protocol_err}, 64'd0);
    rst = 1'b0;
    cyc();
    check_eq("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // 1. single Get, two-cycle issue latency, response after a few cycles
    a_ready = 1'b1;
    push_cmd(3'd4, 64'h1000, 64'd0);
    check_eq("t1_latency_a_valid", {63'd0, a_valid}, 64'd0);
    cyc();
    check_eq("t1_a_valid", {63'd0, a_valid}, 64'd1);
    check_eq("t1_a_address", a_address, 64'h1000);
    check_eq("t1_a_opcode", {61'd0, a_opcode}, 64'd4);
    check_eq("t1_a_param", {61'd0, a_param}, 64'd0);
    check_eq("t1_a_source", {61'd0, a_source}, 64'd0);
    check_eq("t1_outstanding_1", {60'd0, outstanding}, 64'd1);
    cyc();
    check_eq("t1_a_valid_drop", {63'd0, a_valid}, 64'd0);
    repeat (2) cyc();
    send_d(3'd0, 3'd1, 64'hDEADBEEF, 1'b0);
    check_eq("t1_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check_eq("t1_rsp_data", rsp_data, 64'hDEADBEEF);
    check_eq("t1_rsp_source", {61'd0, rsp_source}, 64'd0);
    check_eq("t1_rsp_opcode", {61'd0, rsp_opcode}, 64'd1);
    check_eq("t1_outstanding_0", {60'd0, outstanding}, 64'd0);
    cyc();
    check_eq("t1_rsp_consumed", {63'd0, rsp_valid}, 64'd0);

    // 2. four back-to-back Puts fill every ID; a fifth waits for a freed ID
    push_cmd(3'd0, 64'h2000, 64'h20);
    for (int k = 1; k <= 4; k++) begin
      push_cmd(3'd0, 64'h2000 + 64'(k * 8), 64'h20 + 64'(k));
      check_eq("t2_a_valid", {63'd0, a_valid}, 64'd1);
      check_eq("t2_a_source", {61'd0, a_source}, 64'(k - 1));
      check_eq("t2_a_address", a_address, 64'h2000 + 64'((k - 1) * 8));
    end
    cyc();
    check_eq("t2_full_a_valid", {63'd0, a_valid}, 64'd0);
    check_eq("t2_full_outstanding", {60'd0, outstanding}, 64'd4);
    repeat (2) cyc();
    check_eq("t2_waiting_a_valid", {63'd0, a_valid}, 64'd0);
    send_d(3'd1, 3'd0, 64'd0, 1'b0);
    check_eq("t2_freed_a_valid_next", {63'd0, a_valid}, 64'd0);
    check_eq("t2_freed_outstanding", {60'd0, outstanding}, 64'd3);
    cyc();
    check_eq("t2_fifth_a_valid", {63'd0, a_valid}, 64'd1);
    check_eq("t2_fifth_a_source", {61'd0, a_source}, 64'd1);
    check_eq("t2_fifth_a_address", a_address, 64'h2020);
    check_eq("t2_fifth_outstanding", {60'd0, outstanding}, 64'd4);
    cyc();
    send_d(3'd0, 3'd0, 64'd0, 1'b0);
    send_d(3'd2, 3'd0, 64'd0, 1'b0);
    send_d(3'd3, 3'd0, 64'd0, 1'b0);
    send_d(3'd1, 3'd0, 64'd0, 1'b0);
    check_eq("t2_drained", {60'd0, outstanding}, 64'd0);
    check_eq("t2_protocol_err", {63'd0, protocol_err}, 64'd0);

    // 3. a_ready low for five cycles: payload frozen, issued exactly once
    a_ready = 1'b0;
    base = a_hs_cnt;
    push_cmd(3'd4, 64'h3000, 64'd0);
    cyc();
    for (int k = 0; k < 5; k++) begin
      check_eq("t3_hold_a_valid", {63'd0, a_valid}, 64'd1);
      check_eq("t3_hold_a_address", a_address, 64'h3000);
      cyc();
    end
    a_ready = 1'b1;
    cyc();
    check_eq("t3_released", {63'd0, a_valid}, 64'd0);
    check_eq("t3_issue_count", 64'(a_hs_cnt - base), 64'd1);
    send_d(3'd0, 3'd1, 64'h33, 1'b0);
    cyc();

    // 4. out-of-order D (2,0,1) with back-pressure on the response side
    push_cmd(3'd4, 64'h4000, 64'd0);
    push_cmd(3'd4, 64'h4008, 64'd0);
    push_cmd(3'd4, 64'h4010, 64'd0);
    repeat (4) cyc();
    check_eq("t4_outstanding_3", {60'd0, outstanding}, 64'd3);
    base = rsp_cnt;
    rsp_ready = 1'b0;
    d_valid = 1'b1; d_source = 3'd2; d_opcode = 3'd1; d_data = 64'hA2; d_error = 1'b0;
    #1;
    check_eq("t4_d_ready_empty", {63'd0, d_ready}, 64'd1);
    cyc();
    d_source = 3'd0; d_data = 64'hB0;
    #1;
    check_eq("t4_d_ready_blocked", {63'd0, d_ready}, 64'd0);
    check_eq("t4_rsp_source_2", {61'd0, rsp_source}, 64'd2);
    check_eq("t4_rsp_data_2", rsp_data, 64'hA2);
    cyc();
    check_eq("t4_rsp_data_kept", rsp_data, 64'hA2);
    check_eq("t4_outstanding_2", {60'd0, outstanding}, 64'd2);
    rsp_ready = 1'b1;
    #1;
    check_eq("t4_d_ready_pass", {63'd0, d_ready}, 64'd1);
    cyc();
    d_source = 3'd1; d_data = 64'hC1; rsp_ready = 1'b0;
    #1;
    check_eq("t4_rsp_source_0", {61'd0, rsp_source}, 64'd0);
    check_eq("t4_rsp_data_0", rsp_data, 64'hB0);
    check_eq("t4_d_ready_blocked2", {63'd0, d_ready}, 64'd0);
    cyc();
    rsp_ready = 1'b1;
    cyc();
    d_valid = 1'b0;
    check_eq("t4_rsp_source_1", {61'd0, rsp_source}, 64'd1);
    check_eq("t4_rsp_data_1", rsp_data, 64'hC1);
    cyc();
    check_eq("t4_rsp_count", 64'(rsp_cnt - base), 64'd3);
    check_eq("t4_order_0", {61'd0, rsp_log[base % 64]}, 64'd2);
    check_eq("t4_order_1", {61'd0, rsp_log[(base + 1) % 64]}, 64'd0);
    check_eq("t4_order_2", {61'd0, rsp_log[(base + 2) % 64]}, 64'd1);
    check_eq("t4_outstanding_0", {60'd0, outstanding}, 64'd0);
    check_eq("t4_protocol_err", {63'd0, protocol_err}, 64'd0);

    // 5. D for idle source 5, then AccessAck returned for a Get
    base = rsp_cnt;
    send_d(3'd5, 3'd0, 64'h55, 1'b0);
    check_eq("t5_idle_src_err", {63'd0, protocol_err}, 64'd1);
    check_eq("t5_idle_src_dropped", {63'd0, rsp_valid}, 64'd0);
    check_eq("t5_idle_src_no_rsp", 64'(rsp_cnt - base), 64'd0);
    push_cmd(3'd4, 64'h5000, 64'd0);
    repeat (3) cyc();
    send_d(3'd0, 3'd0, 64'h5A, 1'b1);
    check_eq("t5_fwd_valid", {63'd0, rsp_valid}, 64'd1);
    check_eq("t5_fwd_opcode", {61'd0, rsp_opcode}, 64'd0);
    check_eq("t5_fwd_data", rsp_data, 64'h5A);
    check_eq("t5_fwd_error", {63'd0, rsp_error}, 64'd1);
    check_eq("t5_err_sticky", {63'd0, protocol_err}, 64'd1);
    cyc();

    // 6. reset with two commands in flight, late D beat, illegal command
    a_ready = 1'b0;
    push_cmd(3'd0, 64'h6000, 64'd0);
    push_cmd(3'd0, 64'h6008, 64'd0);
    a_ready = 1'b1;
    cyc();
    a_ready = 1'b0;
    check_eq("t6_a_source_1", {61'd0, a_source}, 64'd1);
    check_eq("t6_outstanding_2", {60'd0, outstanding}, 64'd2);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_outstanding", {60'd0, outstanding}, 64'd0);
    check_eq("t6_rst_a_valid", {63'd0, a_valid}, 64'd0);
    check_eq("t6_rst_protocol_err", {63'd0, protocol_err}, 64'd0);
    cyc();
    rst = 1'b0;
    a_ready = 1'b1;
    repeat (2) cyc();
    check_eq("t6_after_rst_a_valid", {63'd0, a_valid}, 64'd0);
    send_d(3'd0, 3'd0, 64'd0, 1'b0);
    check_eq("t6_late_d_err", {63'd0, protocol_err}, 64'd1);
    check_eq("t6_late_d_dropped", {63'd0, rsp_valid}, 64'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    push_cmd(3'd7, 64'h7000, 64'd0);
    check_eq("t6_illegal_err", {63'd0, protocol_err}, 64'd1);
    repeat (2) cyc();
    check_eq("t6_illegal_no_issue", {63'd0, a_valid}, 64'd0);
    check_eq("t6_illegal_outstanding", {60'd0, outstanding}, 64'd0);
    push_cmd(3'd4, 64'h7100, 64'd0);
    cyc();
    check_eq("t6_legal_a_valid", {63'd0, a_valid}, 64'd1);
    check_eq("t6_legal_a_address", a_address, 64'h7100);
    cyc();

`ifdef TL_UL_MASTER_TIMEOUT_EN
    begin
      int waited;
      waited = 0;
      check_eq("t6_timeout_clear", {63'd0, timeout}, 64'd0);
      while (!timeout && waited < 1100) begin
        cyc();
        waited++;
      end
      check_eq("t6_timeout_set", {63'd0, timeout}, 64'd1);
      check_eq("t6_timeout_window", {63'd0, (waited > 1000)}, 64'd1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
